// File: rtl/vec_pkg.sv
// Shared types and Q7.8 constants for the vector-ALU result path.
// Pure declarations: no latency, no flow control.
package vec_pkg;

  localparam int LANES      = 16;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;

  localparam logic [DATA_WIDTH-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_WIDTH-1:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    RED_SUM = 2'b00,
    RED_MAX = 2'b01,
    RED_MIN = 2'b10,
    RED_ABS = 2'b11
  } reduce_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } red_state_t;

endpackage

// File: rtl/q78_saturate.sv
// Clamp a wide signed accumulator into the signed DATA_WIDTH range, flagging clamps.
// Combinational, zero latency; no flow control.
module q78_saturate #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 21
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  sat
);

  localparam logic signed [ACC_WIDTH-1:0] LIM_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] LIM_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] acc_s;

  assign acc_s = acc;

  always_comb begin
    data = acc[DATA_WIDTH-1:0];
    sat  = 1'b0;
    if (acc_s > LIM_MAX) begin
      data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat  = 1'b1;
    end else if (acc_s < LIM_MIN) begin
      data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/vector_reduce_unit.sv
// Folds a LANES-wide Q7.8 vector, one lane per clock, into a saturated scalar (sum/max/min/abs-sum).
// out_valid LANES edges after accept; result held until out_ready, in_ready only while idle.
module vector_reduce_unit import vec_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(LANES) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_vec [LANES],
  input  logic [1:0]            in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat,
  output logic                  out_n,
  output logic                  out_z
);

  localparam int CW = $clog2(LANES);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  red_state_t state, state_nxt;
  reduce_op_t op_q;

  logic [DATA_WIDTH-1:0]       lane_q [LANES];
  logic [CW-1:0]               cnt;
  logic signed [ACC_WIDTH-1:0] acc, acc_nxt, lane_ext, lane_abs, identity;
  logic [DATA_WIDTH-1:0]       sat_data;
  logic                        sat_flag;
  logic                        accept, last;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(LANES - 1));

  assign lane_ext = {{(ACC_WIDTH-DATA_WIDTH){lane_q[cnt][DATA_WIDTH-1]}}, lane_q[cnt]};
  // ACC_WIDTH leaves headroom, so negating the most negative lane cannot wrap.
  assign lane_abs = lane_ext[ACC_WIDTH-1] ? -lane_ext : lane_ext;

  always_comb begin
    identity = '0;
    case (reduce_op_t'(in_op))
      RED_MAX: identity = ACC_MIN;
      RED_MIN: identity = ACC_MAX;
      default: identity = '0;
    endcase
  end

  always_comb begin
    acc_nxt = acc;
    case (op_q)
      RED_SUM: acc_nxt = acc + lane_ext;
      RED_ABS: acc_nxt = acc + lane_abs;
      RED_MAX: acc_nxt = (lane_ext > acc) ? lane_ext : acc;
      RED_MIN: acc_nxt = (lane_ext < acc) ? lane_ext : acc;
      default: acc_nxt = acc;
    endcase
  end

  q78_saturate #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sat (
    .acc  (acc_nxt),
    .data (sat_data),
    .sat  (sat_flag)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = ACCUM;
      ACCUM:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
      op_q     <= RED_SUM;
      cnt      <= '0;
      acc      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
      out_n    <= 1'b0;
      out_z    <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < LANES; i++) lane_q[i] <= in_vec[i];
        op_q <= reduce_op_t'(in_op);
        cnt  <= '0;
        acc  <= identity;
      end else if (state == ACCUM) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        // Output registers load only here, so they stay frozen through DONE.
        if (last) begin
          out_data <= sat_data;
          out_sat  <= sat_flag;
          out_n    <= sat_data[DATA_WIDTH-1];
          out_z    <= (sat_data == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_reduce_unit.sv
// Scoreboarded bench for vector_reduce_unit: directed vectors, latency, backpressure, async abort.
module tb_vector_reduce_unit;
  import vec_pkg::*;

  typedef logic [15:0] vec_t [16];
  typedef struct packed {
    logic [15:0] data;
    logic        sat;
    logic        n;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec [16];
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_n;
  logic        out_z;

  res_t  sb [$];
  string nm [$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  vector_reduce_unit #(
    .DATA_WIDTH (16),
    .LANES      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_n     (out_n),
    .out_z     (out_z)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic res_t res(input logic [15:0] d, input logic s, input logic n, input logic z);
    res_t r;
    r.data = d;
    r.sat  = s;
    r.n    = n;
    r.z    = z;
    return r;
  endfunction

  function automatic vec_t fill(input logic [15:0] even, input logic [15:0] odd);
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = i[0] ? odd : even;
    return v;
  endfunction

  // Monitor: every presented result that downstream takes is checked against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      res_t  g, e;
      string n;
      g = {out_data, out_sat, out_n, out_z};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h, expected no result", g);
      end else begin
        e = sb.pop_front();
        n = nm.pop_front();
        chk(n, 32'(g), 32'(e));
      end
    end
  end

  task automatic send(input string name, input vec_t v, input logic [1:0] op,
                      input res_t e, input bit push, input bit lat);
    int n;
    bit early;
    n     = 0;
    early = 1'b0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got in_ready=0, expected 1", name);
      return;
    end
    in_vec   = v;
    in_op    = op;
    in_valid = 1'b1;
    if (push) begin
      sb.push_back(e);
      nm.push_back(name);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (lat) begin
      for (int k = 1; k < 16; k++) begin
        @(posedge clk);
        #1 if (out_valid) early = 1'b1;
      end
      @(posedge clk);
      #1 chk({name, "_latency"}, 32'({early, out_valid}), 32'h1);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    vec_t v;
    res_t held;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    out_ready = 1'b1;
    in_vec    = fill(16'h0000, 16'h0000);

    #12 chk("reset_state", 32'({out_valid, in_ready, out_data, out_sat, out_n, out_z}), 32'h0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) chk("ready_after_reset", 32'(in_ready), 32'h1);

    send("sum_ones",    fill(16'h0100, 16'h0100), 2'b00, res(16'h1000, 0, 0, 0), 1, 1);
    send("sum_cancel",  fill(16'h0100, 16'hFF00), 2'b00, res(16'h0000, 0, 0, 1), 1, 0);
    send("sum_sat_pos", fill(16'h7000, 16'h7000), 2'b00, res(Q_MAX,      1, 0, 0), 1, 0);
    send("sum_sat_neg", fill(16'h8000, 16'h8000), 2'b00, res(Q_MIN,      1, 1, 0), 1, 0);
    v = fill(16'hFF00, 16'hFF00);
    v[9] = 16'h0280;
    send("max_lane9",   v,                        2'b01, res(16'h0280, 0, 0, 0), 1, 1);
    v = fill(16'h0000, 16'h0000);
    v[15] = 16'h8000;
    send("min_lane15",  v,                        2'b10, res(Q_MIN,      0, 1, 0), 1, 0);
    send("abs_sat",     fill(16'h8000, 16'h8000), 2'b11, res(Q_MAX,      1, 0, 0), 1, 0);
    send("abs_alt",     fill(16'h0080, 16'hFF80), 2'b11, res(16'h0800, 0, 0, 0), 1, 0);
    send("max_all_min", fill(16'h8000, 16'h8000), 2'b01, res(Q_MIN,      0, 1, 0), 1, 0);
    send("min_all_max", fill(16'h7FFF, 16'h7FFF), 2'b10, res(Q_MAX,      0, 0, 0), 1, 0);
    drain("directed");

    // Backpressure: hold the result for 5 cycles while a second vector waits upstream.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send("bp_first", fill(16'h0100, 16'h0100), 2'b00, res(16'h1000, 0, 0, 0), 1, 1);
    v = fill(16'h0100, 16'h0100);
    v[3] = 16'hFE80;
    in_vec   = v;
    in_op    = 2'b10;
    in_valid = 1'b1;
    sb.push_back(res(16'hFE80, 0, 1, 0));
    nm.push_back("bp_second");
    held = res(16'h1000, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold", 32'({out_valid, in_ready, out_data, out_sat, out_n, out_z}),
          32'({1'b1, 1'b0, held}));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk) chk("bp_ready_after_hs", 32'({out_valid, in_ready}), 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain("backpressure");

    // Abort mid-accumulation; outputs still hold the previous result until rst hits.
    send("rst_abort", fill(16'h0200, 16'h0200), 2'b00, res(16'h0000, 0, 0, 0), 0, 0);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async_outputs", 32'({out_valid, in_ready, out_data, out_sat, out_n, out_z}), 32'h0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) chk("ready_after_abort", 32'(in_ready), 32'h1);
    send("after_abort", fill(16'h0100, 16'h0100), 2'b00, res(16'h1000, 0, 0, 0), 1, 1);
    drain("final");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
